// File: rtl/state_pkg.sv
// state_pkg: state encoding shared by the mode controller and the LED decoder.
package state_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces a raw button; one-cycle pulse on accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, lvl_d;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      lvl_d <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= level;
      press <= level & ~lvl_d;
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/state_ctrl.sv
// state_ctrl: IDLE/RUN/PAUSE/ALARM mode sequencer with debounced buttons and PAUSE timeout.
module state_ctrl
  import state_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 16,
  localparam int CNT_W = $clog2(((DEBOUNCE_CYCLES > TIMEOUT_CYCLES) ? DEBOUNCE_CYCLES : TIMEOUT_CYCLES) + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_next,
  input  logic               btn_back,
  input  logic               alarm,
  output logic [STATE_W-1:0] state,
  output logic               state_changed
);
  state_t state_q, state_n;
  logic next_p, back_p, a1, alarm_s;
  logic [1:0] unused_level;
  logic [CNT_W-1:0] tcnt;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst_n(rst_n), .raw(btn_next), .level(unused_level[0]), .press(next_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk(clk), .rst_n(rst_n), .raw(btn_back), .level(unused_level[1]), .press(back_p)
  );
  assign state = state_q;
  always_comb begin
    state_n = state_q;
    if (alarm_s && state_q != ST_ALARM) state_n = ST_ALARM;
    else case (state_q)
      ST_ALARM: state_n = (!alarm_s && next_p) ? ST_IDLE : ST_ALARM;
      ST_IDLE:  state_n = next_p ? ST_RUN : ST_IDLE;
      ST_RUN:   state_n = back_p ? ST_IDLE : next_p ? ST_PAUSE : ST_RUN;
      default:  state_n = back_p ? ST_IDLE : next_p ? ST_RUN :
                          (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) ? ST_IDLE : ST_PAUSE;
    endcase
  end
  // Timeout counts only while PAUSE persists, so entry and any exit both leave it at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1            <= 1'b0;
      alarm_s       <= 1'b0;
      state_q       <= ST_IDLE;
      state_changed <= 1'b0;
      tcnt          <= '0;
    end else begin
      a1            <= alarm;
      alarm_s       <= a1;
      state_q       <= state_n;
      state_changed <= state_n != state_q;
      tcnt          <= (state_q == ST_PAUSE && state_n == ST_PAUSE) ? tcnt + CNT_W'(1) : '0;
    end
  end
endmodule

// File: tb/tb_state_ctrl.sv
// tb_state_ctrl: directed self-checking bench for the state_ctrl mode sequencer.
module tb_state_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, btn_next = 1'b0, btn_back = 1'b0, alarm = 1'b0;
  logic [1:0] state;
  logic state_changed;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  state_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_back(btn_back),
    .alarm(alarm), .state(state), .state_changed(state_changed)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw rise just after an edge held 4 cycles; new state becomes visible 8 edges after the rise.
  task automatic press(input bit back);
    if (back) btn_back = 1'b1;
    else btn_next = 1'b1;
    tick(4);
    btn_back = 1'b0;
    btn_next = 1'b0;
  endtask

  task automatic press_settle(input bit back);
    press(back);
    tick(7);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    btn_next = 1'b1;
    btn_back = 1'b1;
    tick(3);
    n_checks++;
    if (state !== 2'd0) begin $display("FAIL reset_state: got %0d expected 0", state); n_fail++; end
    n_checks++;
    if (state_changed !== 1'b0) begin $display("FAIL reset_changed: got %b expected 0", state_changed); n_fail++; end
    btn_next = 1'b0;
    btn_back = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      n_checks++;
      if (state !== 2'd0 || state_changed !== 1'b0) begin
        $display("FAIL post_reset_idle cyc%0d: got state=%0d chg=%b expected state=0 chg=0", i, state, state_changed);
        n_fail++;
      end
    end
  endtask

  task automatic test_full_cycle;
    bit bk[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] pv[4] = '{2'd0, 2'd1, 2'd2, 2'd1};
    logic [1:0] ex[4] = '{2'd1, 2'd2, 2'd1, 2'd0};
    for (int r = 0; r < 4; r++) begin
      press(bk[r]);
      tick(3);
      n_checks++;
      if (state !== pv[r] || state_changed !== 1'b0) begin
        $display("FAIL cycle_early row%0d: got state=%0d chg=%b expected state=%0d chg=0", r, state, state_changed, pv[r]);
        n_fail++;
      end
      tick(1);
      n_checks++;
      if (state !== ex[r] || state_changed !== 1'b1) begin
        $display("FAIL cycle_change row%0d: got state=%0d chg=%b expected state=%0d chg=1", r, state, state_changed, ex[r]);
        n_fail++;
      end
      tick(1);
      n_checks++;
      if (state_changed !== 1'b0) begin
        $display("FAIL cycle_pulse_width row%0d: got chg=%b expected 0", r, state_changed);
        n_fail++;
      end
      tick(3);
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 30; i++) begin
      btn_next = (i % 6) < 3;
      tick(1);
      n_checks++;
      if (state !== 2'd0 || state_changed !== 1'b0) begin
        $display("FAIL bounce_reject cyc%0d: got state=%0d chg=%b expected state=0 chg=0", i, state, state_changed);
        n_fail++;
      end
    end
    btn_next = 1'b0;
    tick(4);
    press(1'b0);
    tick(3);
    n_checks++;
    if (state !== 2'd0) begin $display("FAIL bounce_min_early: got %0d expected 0", state); n_fail++; end
    tick(1);
    n_checks++;
    if (state !== 2'd1 || state_changed !== 1'b1) begin
      $display("FAIL bounce_min_accept: got state=%0d chg=%b expected state=1 chg=1", state, state_changed);
      n_fail++;
    end
    tick(3);
    press_settle(1'b1);
    n_checks++;
    if (state !== 2'd0) begin $display("FAIL bounce_back_idle: got %0d expected 0", state); n_fail++; end
  endtask

  task automatic test_timeout;
    press_settle(1'b0);
    press(1'b0);
    tick(4);
    n_checks++;
    if (state !== 2'd2) begin $display("FAIL timeout_enter: got %0d expected 2", state); n_fail++; end
    tick(15);
    n_checks++;
    if (state !== 2'd2) begin $display("FAIL timeout_hold15: got %0d expected 2", state); n_fail++; end
    tick(1);
    n_checks++;
    if (state !== 2'd0 || state_changed !== 1'b1) begin
      $display("FAIL timeout_expire: got state=%0d chg=%b expected state=0 chg=1", state, state_changed);
      n_fail++;
    end
    press_settle(1'b0);
    press(1'b0);
    tick(4);
    n_checks++;
    if (state !== 2'd2) begin $display("FAIL timeout_reenter: got %0d expected 2", state); n_fail++; end
    tick(2);
    press(1'b0);
    tick(3);
    n_checks++;
    if (state !== 2'd2) begin $display("FAIL timeout_press_early: got %0d expected 2", state); n_fail++; end
    tick(1);
    n_checks++;
    if (state !== 2'd1 || state_changed !== 1'b1) begin
      $display("FAIL timeout_press_run: got state=%0d chg=%b expected state=1 chg=1", state, state_changed);
      n_fail++;
    end
    tick(6);
    n_checks++;
    if (state !== 2'd1) begin $display("FAIL timeout_none_in_run: got %0d expected 1", state); n_fail++; end
  endtask

  task automatic test_alarm;
    alarm = 1'b1;
    btn_back = 1'b1;
    tick(2);
    n_checks++;
    if (state !== 2'd1) begin $display("FAIL alarm_sync_delay: got %0d expected 1", state); n_fail++; end
    tick(1);
    n_checks++;
    if (state !== 2'd3 || state_changed !== 1'b1) begin
      $display("FAIL alarm_enter: got state=%0d chg=%b expected state=3 chg=1", state, state_changed);
      n_fail++;
    end
    tick(1);
    btn_back = 1'b0;
    tick(6);
    n_checks++;
    if (state !== 2'd3 || state_changed !== 1'b0) begin
      $display("FAIL alarm_back_ignored: got state=%0d chg=%b expected state=3 chg=0", state, state_changed);
      n_fail++;
    end
    press(1'b0);
    tick(8);
    n_checks++;
    if (state !== 2'd3 || state_changed !== 1'b0) begin
      $display("FAIL alarm_next_ignored: got state=%0d chg=%b expected state=3 chg=0", state, state_changed);
      n_fail++;
    end
    alarm = 1'b0;
    tick(5);
    n_checks++;
    if (state !== 2'd3) begin $display("FAIL alarm_clear_holds: got %0d expected 3", state); n_fail++; end
    press(1'b0);
    tick(3);
    n_checks++;
    if (state !== 2'd3) begin $display("FAIL alarm_exit_early: got %0d expected 3", state); n_fail++; end
    tick(1);
    n_checks++;
    if (state !== 2'd0 || state_changed !== 1'b1) begin
      $display("FAIL alarm_exit_idle: got state=%0d chg=%b expected state=0 chg=1", state, state_changed);
      n_fail++;
    end
    tick(3);
  endtask

  task automatic test_async_reset;
    press_settle(1'b0);
    press(1'b0);
    tick(4);
    n_checks++;
    if (state !== 2'd2) begin $display("FAIL areset_pause: got %0d expected 2", state); n_fail++; end
    tick(8);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 2'd0 || state_changed !== 1'b0) begin
      $display("FAIL areset_immediate: got state=%0d chg=%b expected state=0 chg=0", state, state_changed);
      n_fail++;
    end
    #4 rst_n = 1'b1;
    tick(1);
    n_checks++;
    if (state !== 2'd0 || state_changed !== 1'b0) begin
      $display("FAIL areset_release: got state=%0d chg=%b expected state=0 chg=0", state, state_changed);
      n_fail++;
    end
    tick(20);
    n_checks++;
    if (state !== 2'd0) begin $display("FAIL areset_no_pending: got %0d expected 0", state); n_fail++; end
    press(1'b0);
    tick(3);
    n_checks++;
    if (state !== 2'd0) begin $display("FAIL areset_fresh_early: got %0d expected 0", state); n_fail++; end
    tick(1);
    n_checks++;
    if (state !== 2'd1 || state_changed !== 1'b1) begin
      $display("FAIL areset_fresh_press: got state=%0d chg=%b expected state=1 chg=1", state, state_changed);
      n_fail++;
    end
  endtask

  initial begin
    test_reset;
    test_full_cycle;
    test_bounce;
    test_timeout;
    test_alarm;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
